// File: rtl/hshrink_gen.sv
// Horizontal-shrink pixel-enable generator: latches a shrink code per tile and
// streams the resulting keep mask LANES pixels per enabled clock.
module hshrink_gen #(
  parameter int SHRINK_W = 4,
  parameter int LANES    = 2
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                CK_EN,
  input  logic                nLOAD,
  input  logic [SHRINK_W-1:0] SHRINK,
  input  logic                FLIP,
  output logic [LANES-1:0]    OUT,
  output logic                VALID,
  output logic                LAST,
  output logic [SHRINK_W:0]   KEPT
);

  localparam int N      = 1 << SHRINK_W;
  localparam int DEPTH  = N / LANES;
  localparam int STEP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  state_t              state, state_nxt;
  logic [N-1:0]        mask, mask_nxt, load_mask;
  logic [STEP_W-1:0]   step, step_nxt;
  logic [SHRINK_W:0]   kept, kept_nxt;

  function automatic logic [SHRINK_W-1:0] bitrev(input logic [SHRINK_W-1:0] v);
    logic [SHRINK_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < SHRINK_W; b++) begin
      r[b] = v[SHRINK_W-1-b];
    end
    return r;
  endfunction

  // N-1-p within SHRINK_W bits is simply ~p, so flip needs no subtractor.
  always_comb begin
    logic [SHRINK_W-1:0] pv;
    logic [SHRINK_W-1:0] q;
    load_mask = '0;
    pv        = '0;
    q         = '0;
    for (int unsigned p = 0; p < N; p++) begin
      pv           = SHRINK_W'(p);
      q            = FLIP ? ~pv : pv;
      load_mask[p] = (bitrev(q) <= SHRINK);
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state <= ST_IDLE;
      mask  <= '0;
      step  <= '0;
      kept  <= '0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
      step  <= step_nxt;
      kept  <= kept_nxt;
    end
  end

  // A load always wins over an advance, including on the final step.
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    step_nxt  = step;
    kept_nxt  = kept;
    if (CK_EN) begin
      if (!nLOAD) begin
        state_nxt = ST_EMIT;
        mask_nxt  = load_mask;
        step_nxt  = '0;
        kept_nxt  = {1'b0, SHRINK} + (SHRINK_W + 1)'(1);
      end else if (state == ST_EMIT) begin
        if (step == LAST_STEP) begin
          state_nxt = ST_IDLE;
          step_nxt  = '0;
        end else begin
          step_nxt = step + STEP_W'(1);
        end
      end
    end
  end

  always_comb begin
    VALID = (state == ST_EMIT);
    LAST  = VALID && (step == LAST_STEP);
    KEPT  = kept;
    OUT   = '0;
    if (VALID) begin
      OUT = mask[int'(step) * LANES +: LANES];
    end
  end

endmodule

// File: tb/tb_hshrink_gen.sv
// Bench for hshrink_gen: default and (SHRINK_W=5, LANES=4) instances checked
// against a pixel-level keep-rule model under directed and random stimulus.
module tb_hshrink_gen;

  logic       clk = 1'b0;
  logic       nreset;
  logic       ck_en;
  logic       nload;
  logic       flip;
  logic [3:0] sa;
  logic [4:0] sb;
  logic [1:0] out_a;
  logic       valid_a, last_a;
  logic [4:0] kept_a;
  logic [3:0] out_b;
  logic       valid_b, last_b;
  logic [5:0] kept_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hshrink_gen dut_a (
    .CLK(clk), .nRESET(nreset), .CK_EN(ck_en), .nLOAD(nload),
    .SHRINK(sa), .FLIP(flip),
    .OUT(out_a), .VALID(valid_a), .LAST(last_a), .KEPT(kept_a)
  );

  hshrink_gen #(.SHRINK_W(5), .LANES(4)) dut_b (
    .CLK(clk), .nRESET(nreset), .CK_EN(ck_en), .nLOAD(nload),
    .SHRINK(sb), .FLIP(flip),
    .OUT(out_b), .VALID(valid_b), .LAST(last_b), .KEPT(kept_b)
  );

  // Reference model: per-instance pixel keep array, step index, valid and kept.
  int mw[2] = '{4, 5};
  int ml[2] = '{2, 4};
  int mm[2][32];
  int ms[2];
  int mv[2];
  int mk[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rev(input int q, input int w);
    int r = 0;
    for (int b = 0; b < w; b++) r = r * 2 + ((q >> b) & 1);
    return r;
  endfunction

  function automatic int depth(input int i);
    return (1 << mw[i]) / ml[i];
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 32; p++) mm[i][p] = 0;
      ms[i] = 0; mv[i] = 0; mk[i] = 0;
    end
  endtask

  task automatic upd(input int i);
    int n, s;
    n = 1 << mw[i];
    s = (i == 0) ? int'(sa) : int'(sb);
    if (!nreset) begin
      mreset();
    end else if (ck_en) begin
      if (!nload) begin
        for (int p = 0; p < n; p++)
          mm[i][p] = (rev(flip ? (n - 1 - p) : p, mw[i]) <= s) ? 1 : 0;
        ms[i] = 0; mv[i] = 1; mk[i] = s + 1;
      end else if (mv[i] != 0) begin
        if (ms[i] == depth(i) - 1) begin
          mv[i] = 0; ms[i] = 0;
        end else begin
          ms[i]++;
        end
      end
    end
  endtask

  function automatic int exp_out(input int i);
    int r = 0;
    if (mv[i] != 0)
      for (int l = 0; l < ml[i]; l++) r |= mm[i][ms[i] * ml[i] + l] << l;
    return r;
  endfunction

  function automatic int exp_last(input int i);
    return (mv[i] != 0 && ms[i] == depth(i) - 1) ? 1 : 0;
  endfunction

  task automatic compare();
    chk("out_a",   64'(out_a),   64'(exp_out(0)));
    chk("valid_a", 64'(valid_a), 64'(mv[0]));
    chk("last_a",  64'(last_a),  64'(exp_last(0)));
    chk("kept_a",  64'(kept_a),  64'(mk[0]));
    chk("out_b",   64'(out_b),   64'(exp_out(1)));
    chk("valid_b", 64'(valid_b), 64'(mv[1]));
    chk("last_b",  64'(last_b),  64'(exp_last(1)));
    chk("kept_b",  64'(kept_b),  64'(mk[1]));
  endtask

  task automatic cyc();
    @(posedge clk);
    upd(0);
    upd(1);
    #1;
    compare();
  endtask

  task automatic ld(input int s_a, input int s_b, input logic f);
    ck_en = 1'b1; nload = 1'b0; sa = 4'(s_a); sb = 5'(s_b); flip = f;
    cyc();
    nload = 1'b1;
    sa = 4'($urandom); sb = 5'($urandom); flip = 1'($urandom);
  endtask

  task automatic run(input int n);
    ck_en = 1'b1;
    repeat (n) cyc();
  endtask

  initial begin
    int pc, edges;
    int pat[4] = '{1, 0, 0, 1};
    nreset = 1'b0; ck_en = 1'b0; nload = 1'b1; flip = 1'b0; sa = '0; sb = '0;
    mreset();
    #12;
    compare();
    nreset = 1'b1;
    run(2);

    // Full width on both instances
    ld(15, 31, 1'b0);
    chk("full_kept_a", 64'(kept_a), 64'd16);
    chk("full_kept_b", 64'(kept_b), 64'd32);
    for (int k = 0; k < 8; k++) begin
      chk("full_out_a", 64'(out_a), 64'h3);
      chk("full_out_b", 64'(out_b), 64'hF);
      chk("full_last_a", 64'(last_a), 64'(k == 7));
      if (k < 7) run(1);
    end
    run(1);
    chk("full_end_valid", 64'(valid_a), 64'd0);
    chk("full_end_out", 64'(out_a), 64'd0);

    // Partial shrink S=11
    ld(11, 5, 1'b0);
    pc = 0;
    for (int k = 0; k < 8; k++) begin
      chk("part_out", 64'(out_a), (k % 2 == 1) ? 64'h1 : 64'h3);
      pc += $countones(out_a);
      if (k < 7) run(1);
    end
    chk("part_pop", 64'(pc), 64'd12);
    run(1);

    // Minimum shrink, with and without flip
    ld(0, 0, 1'b0);
    chk("min_out0", 64'(out_a), 64'h1);
    run(8);
    ld(0, 0, 1'b1);
    chk("minf_out0", 64'(out_a), 64'h0);
    run(7);
    chk("minf_out7", 64'(out_a), 64'h2);
    run(1);

    // Clock gating: count enabled edges from load to end of tile
    ld(7, 9, 1'b0);
    edges = 0;
    for (int k = 0; k < 40 && valid_a; k++) begin
      ck_en = 1'(pat[k % 4]);
      if (ck_en) edges++;
      cyc();
      if (valid_a) chk("gate_out", 64'(out_a), 64'h1);
    end
    chk("gate_len", 64'(edges), 64'd8);

    // Mid-tile reload, then back-to-back load on the last step
    ld(15, 31, 1'b0);
    run(3);
    ld(7, 3, 1'b0);
    chk("reload_out", 64'(out_a), 64'h1);
    edges = 0;
    for (int k = 0; k < 20 && !last_a; k++) begin
      run(1);
      edges++;
    end
    chk("reload_last", 64'(edges), 64'd7);
    ld(13, 20, 1'b1);
    chk("b2b_valid", 64'(valid_a), 64'd1);
    run(8);

    // Asynchronous reset mid-tile
    ld(15, 31, 1'b0);
    run(4);
    #2;
    nreset = 1'b0;
    #1;
    mreset();
    chk("rst_out", 64'(out_a), 64'd0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_kept", 64'(kept_a), 64'd0);
    compare();
    run(2);
    nreset = 1'b1;
    run(2);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      ck_en = ($urandom % 4) != 0;
      nload = ($urandom % 7) != 0;
      sa    = 4'($urandom);
      sb    = 5'($urandom);
      flip  = 1'($urandom);
      if (($urandom % 150) == 0) begin
        nreset = 1'b0;
        #1;
        mreset();
        compare();
        cyc();
        nreset = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
